ram_bist: RTL and testbench
===========================

# ram_bist

Parametrised RAM self-test engine that turns the single write/seek/read/compare check into a hardware sequencer. It writes a data pattern over an address range, reads the range back and compares each word, then reports pass/fail, a saturating error count and details of the first failure. It is a bus master that sits beside the SPI bridge on the shared RAM bus arbiter, and lets firmware run a full-range RAM check without per-byte SPI traffic.

## Interface
- `DATA_WIDTH`, default 8: bus data width; must be a power of two.
- `ADDR_WIDTH`, default 17: RAM address width.
- `ERR_WIDTH`, default 16: width of the error counter.
- `clock_i`  in  1  system clock; the only clock.
- `reset_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  one-cycle start request.
- `abort_i`  in  1  one-cycle abort request.
- `mode_i`  in  2  pattern mode, sampled at start.
- `pattern_i`  in  DATA_WIDTH  pattern seed, sampled at start.
- `first_addr_i`, `last_addr_i`  in  ADDR_WIDTH  inclusive range, sampled at start.
- `bus_addr_o`  out  ADDR_WIDTH  access address.
- `bus_data_o`  out  DATA_WIDTH  write data.
- `bus_we_o`  out  1  1 = write, 0 = read.
- `bus_strobe_o`  out  1  one-cycle access request.
- `bus_done_i`  in  1  access complete; read data is valid in the same cycle.
- `bus_data_i`  in  DATA_WIDTH  read data.
- `busy_o`  out  1  test in progress.
- `done_o`  out  1  one-cycle completion pulse.
- `pass_o`  out  1  1 when the last test completed with zero errors.
- `aborted_o`, `range_error_o`  out  1 each  termination cause.
- `error_count_o`  out  ERR_WIDTH  mismatches; saturates at all-ones.
- `fail_addr_o`  out  ADDR_WIDTH  address of the first mismatch.
- `fail_expected_o`, `fail_actual_o`  out  DATA_WIDTH each  expected and actual data of the first mismatch.

## Operation
- States: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FINISH.
- IDLE:
  - `start_i` latches the inputs and clears all result outputs. Next state is WR_REQ at `first_addr`.
  - `start_i` while busy is ignored.
- *_REQ:
  - `bus_strobe_o` is high for exactly this cycle.
  - `bus_addr_o`, `bus_data_o` and `bus_we_o` are driven here and held unchanged until `bus_done_i`.
  - The block then goes to *_WAIT.
- *_WAIT: the block waits for `bus_done_i`.
  - If addr == last: WR_WAIT goes to RD_REQ at `first_addr`, and RD_WAIT goes to FINISH.
  - Otherwise addr increments and the block returns to the same *_REQ.
  - The last-address test is done before incrementing, so `last_addr` = all-ones does not wrap.
- Expected data `exp(a)` depends on `mode_i`:
  - 0: `pattern`.
  - 1: `a[DATA_WIDTH-1:0] ^ pattern`.
  - 2: walking one, `1 << a[log2(DATA_WIDTH)-1:0]`; the pattern is ignored.
  - 3: `a[0] ? ~pattern : pattern`.
- Read compare: in the RD_WAIT cycle where `bus_done_i` is high, `bus_data_i` is compared with `exp(addr)`.
  - On mismatch, `error_count` increments with saturation.
  - The fail_* outputs capture only the first mismatch.
- FINISH:
  - `done_o` is high for one cycle.
  - `pass_o` = (errors == 0) & ~aborted & ~range_error.
  - Next state is IDLE.
  - Results hold until the next accepted start.
- Range error: if `first_addr` > `last_addr` at start, no bus access is made, `range_error_o` = 1, and the block goes directly to FINISH.
- `first_addr` == `last_addr`: one write and one read.
- Abort:
  - `abort_i` in any busy state is latched.
  - An outstanding access (*_WAIT) always completes first; a bus transaction is never abandoned.
  - At the next *_REQ boundary the block goes to FINISH instead of issuing a strobe, with `aborted_o` = 1.
- `bus_done_i` outside the *_WAIT states is ignored.
- Reset mid-test:
  - All state goes to IDLE and `bus_strobe_o` is low from the next cycle.
  - An in-flight `bus_done_i` is ignored.

## Timing
- Reset values of all outputs are 0.
- `busy_o` rises the cycle after `start_i`. The first strobe is in that same cycle.
- With bus latency L ≥ 1 (`bus_done_i` arrives L cycles after the strobe), each access takes L+1 cycles.
- For N = last − first + 1:
  - The final `bus_done_i` arrives at cycle 2N(L+1) after the start cycle.
  - `done_o` is at cycle 2N(L+1)+1.
  - `busy_o` falls in the same cycle as `done_o`.
- There is no idle cycle between the write pass and the read pass.
- Range error: `done_o` is 2 cycles after `start_i`, with no strobe.
- `bus_strobe_o` is never high in two consecutive cycles.

## Test plan
- Mock RAM with L=2, mode 0, pattern 8'hA5, range 0x00000–0x000FF → 512 strobes; `done_o` at cycle 1537; `pass_o`=1; `error_count_o`=0.
- Mode 1, pattern 8'h00, range 0x1FFF0–0x1FFFF → reads return the low address byte; pass; `bus_addr_o` never wraps past 0x1FFFF.
- Mock RAM bit 3 stuck-at-0, mode 2, range 0x00000–0x0000F → `error_count_o`=2; `fail_addr_o`=0x00003, `fail_expected_o`=8'h08, `fail_actual_o`=8'h00; `pass_o`=0.
- `first_addr_i`=0x00010, `last_addr_i`=0x0000F → no strobe; `range_error_o`=1; `done_o` at cycle 2.
- `abort_i` during the third write's WAIT → that access completes; no further strobe; `aborted_o`=1; `pass_o`=0. `start_i` while busy is ignored.
- `reset_i` asserted mid read pass → the next cycle has `busy_o`=0, `bus_strobe_o`=0 and all results 0; a subsequent full test passes.

Source files
------------

// File: rtl/ram_bist.sv
// ram_bist: write-then-read RAM self test over an inclusive address range, one bus access at a time.
// Latency: first strobe the cycle after start; done_o at 2N(L+1)+1 cycles after start for bus latency L.
// Backpressure: each access holds addr/data/we until bus_done_i; abort waits for any outstanding access.
module ram_bist #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 17,
  parameter int ERR_WIDTH  = 16
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [1:0]            mode_i,
  input  logic [DATA_WIDTH-1:0] pattern_i,
  input  logic [ADDR_WIDTH-1:0] first_addr_i,
  input  logic [ADDR_WIDTH-1:0] last_addr_i,
  output logic [ADDR_WIDTH-1:0] bus_addr_o,
  output logic [DATA_WIDTH-1:0] bus_data_o,
  output logic                  bus_we_o,
  output logic                  bus_strobe_o,
  input  logic                  bus_done_i,
  input  logic [DATA_WIDTH-1:0] bus_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  aborted_o,
  output logic                  range_error_o,
  output logic [ERR_WIDTH-1:0]  error_count_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [DATA_WIDTH-1:0] fail_expected_o,
  output logic [DATA_WIDTH-1:0] fail_actual_o
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, FINISH} state_t;

  typedef struct packed {
    logic [1:0]            mode;
    logic [DATA_WIDTH-1:0] pattern;
    logic [ADDR_WIDTH-1:0] first;
    logic [ADDR_WIDTH-1:0] last;
  } cfg_t;

  localparam logic [DATA_WIDTH-1:0] BIT_IDX_MASK = DATA_WIDTH'(DATA_WIDTH - 1);

  state_t state;
  cfg_t   cfg;
  logic   abort_pend;

  logic                  mismatch;
  logic                  abort_hit;
  logic                  at_last;
  logic [ERR_WIDTH-1:0]  err_next;
  logic [ADDR_WIDTH-1:0] addr_inc;

  function automatic logic [DATA_WIDTH-1:0] exp_data(input logic [1:0]            mode,
                                                     input logic [DATA_WIDTH-1:0] pat,
                                                     input logic [ADDR_WIDTH-1:0] a);
    logic [DATA_WIDTH-1:0] a_lo;
    a_lo = DATA_WIDTH'(a);
    case (mode)
      2'd0:    exp_data = pat;
      2'd1:    exp_data = a_lo ^ pat;
      2'd2:    exp_data = DATA_WIDTH'(1) << (a_lo & BIT_IDX_MASK);
      default: exp_data = a[0] ? ~pat : pat;
    endcase
  endfunction

  // bus_data_o always carries exp(bus_addr_o), so reads compare against it directly.
  always_comb begin
    mismatch  = (state == RD_WAIT) && bus_done_i && (bus_data_i != bus_data_o);
    err_next  = error_count_o;
    if (mismatch && (error_count_o != '1)) err_next = error_count_o + ERR_WIDTH'(1);
    abort_hit = abort_pend || abort_i;
    at_last   = (bus_addr_o == cfg.last);
    addr_inc  = bus_addr_o + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state           <= IDLE;
      cfg             <= '0;
      abort_pend      <= 1'b0;
      bus_addr_o      <= '0;
      bus_data_o      <= '0;
      bus_we_o        <= 1'b0;
      bus_strobe_o    <= 1'b0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      pass_o          <= 1'b0;
      aborted_o       <= 1'b0;
      range_error_o   <= 1'b0;
      error_count_o   <= '0;
      fail_addr_o     <= '0;
      fail_expected_o <= '0;
      fail_actual_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            cfg             <= '{mode: mode_i, pattern: pattern_i, first: first_addr_i, last: last_addr_i};
            abort_pend      <= 1'b0;
            busy_o          <= 1'b1;
            pass_o          <= 1'b0;
            aborted_o       <= 1'b0;
            error_count_o   <= '0;
            fail_addr_o     <= '0;
            fail_expected_o <= '0;
            fail_actual_o   <= '0;
            if (first_addr_i > last_addr_i) begin
              range_error_o <= 1'b1;
              state         <= FINISH;
            end else begin
              range_error_o <= 1'b0;
              bus_addr_o    <= first_addr_i;
              bus_data_o    <= exp_data(mode_i, pattern_i, first_addr_i);
              bus_we_o      <= 1'b1;
              bus_strobe_o  <= 1'b1;
              state         <= WR_REQ;
            end
          end
        end
        WR_REQ, RD_REQ: begin
          bus_strobe_o <= 1'b0;
          if (abort_i) abort_pend <= 1'b1;
          state <= (state == WR_REQ) ? WR_WAIT : RD_WAIT;
        end
        WR_WAIT, RD_WAIT: begin
          if (!bus_done_i) begin
            if (abort_i) abort_pend <= 1'b1;
          end else begin
            if (state == RD_WAIT) begin
              error_count_o <= err_next;
              if (mismatch && (error_count_o == '0)) begin
                fail_addr_o     <= bus_addr_o;
                fail_expected_o <= bus_data_o;
                fail_actual_o   <= bus_data_i;
              end
            end
            // Abort and end-of-read-pass both finish here, before any new strobe.
            if (abort_hit || (at_last && state == RD_WAIT)) begin
              state     <= FINISH;
              done_o    <= 1'b1;
              busy_o    <= 1'b0;
              aborted_o <= abort_hit;
              pass_o    <= !abort_hit && (err_next == '0);
            end else if (at_last) begin
              bus_addr_o   <= cfg.first;
              bus_data_o   <= exp_data(cfg.mode, cfg.pattern, cfg.first);
              bus_we_o     <= 1'b0;
              bus_strobe_o <= 1'b1;
              state        <= RD_REQ;
            end else begin
              bus_addr_o   <= addr_inc;
              bus_data_o   <= exp_data(cfg.mode, cfg.pattern, addr_inc);
              bus_strobe_o <= 1'b1;
              state        <= (state == WR_WAIT) ? WR_REQ : RD_REQ;
            end
          end
        end
        FINISH: begin
          if (done_o) begin
            done_o <= 1'b0;
            state  <= IDLE;
          end else begin
            // Range-error path arrives here without a pulse and takes one extra cycle.
            done_o <= 1'b1;
            busy_o <= 1'b0;
            pass_o <= (error_count_o == '0) && !aborted_o && !range_error_o;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: mock RAM with configurable latency and stuck bits, plus an access-order model.
module tb_ram_bist;
  localparam int DW = 8;
  localparam int AW = 17;
  localparam int EW = 16;

  logic          clock_i;
  logic          reset_i;
  logic          start_i;
  logic          abort_i;
  logic [1:0]    mode_i;
  logic [DW-1:0] pattern_i;
  logic [AW-1:0] first_addr_i;
  logic [AW-1:0] last_addr_i;
  logic [AW-1:0] bus_addr_o;
  logic [DW-1:0] bus_data_o;
  logic          bus_we_o;
  logic          bus_strobe_o;
  logic          bus_done_i;
  logic [DW-1:0] bus_data_i;
  logic          busy_o;
  logic          done_o;
  logic          pass_o;
  logic          aborted_o;
  logic          range_error_o;
  logic [EW-1:0] error_count_o;
  logic [AW-1:0] fail_addr_o;
  logic [DW-1:0] fail_expected_o;
  logic [DW-1:0] fail_actual_o;

  ram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ERR_WIDTH(EW)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
    .mode_i(mode_i), .pattern_i(pattern_i), .first_addr_i(first_addr_i), .last_addr_i(last_addr_i),
    .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o), .bus_we_o(bus_we_o), .bus_strobe_o(bus_strobe_o),
    .bus_done_i(bus_done_i), .bus_data_i(bus_data_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .aborted_o(aborted_o), .range_error_o(range_error_o),
    .error_count_o(error_count_o), .fail_addr_o(fail_addr_o),
    .fail_expected_o(fail_expected_o), .fail_actual_o(fail_actual_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  typedef struct { int addr; bit we; logic [7:0] dat; } acc_t;

  acc_t       m_q[$];
  int         m_lat;
  logic [7:0] m_stuck;
  int         m_done, m_err, m_fail_addr;
  logic [7:0] m_fail_exp, m_fail_act;
  bit         m_abort, m_range;

  int checks, errors;
  int gcyc, t0, done_cyc, n_strobe;
  bit track, mock_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_exp(input int mode, input logic [7:0] pat, input int a);
    case (mode)
      0:       return pat;
      1:       return 8'(a % 256) ^ pat;
      2:       return 8'(1 << (a % 8));
      default: return (a % 2 == 1) ? ~pat : pat;
    endcase
  endfunction

  // Expected access sequence and results straight from the write-pass/read-pass rules.
  task automatic setup_model(input int mode, input logic [7:0] pat, input int first, input int last,
                             input int lat, input logic [7:0] stuck, input int max_acc);
    acc_t a;
    logic [7:0] e, rd;
    m_q.delete();
    m_lat = lat; m_stuck = stuck;
    n_strobe = 0; done_cyc = -1;
    m_err = 0; m_fail_addr = 0; m_fail_exp = 0; m_fail_act = 0;
    m_abort = 0; m_range = (first > last);
    if (m_range) begin
      m_done = 2;
    end else begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i <= last - first; i++) begin
          if (max_acc >= 0 && m_q.size() >= max_acc) begin
            m_abort = 1;
          end else begin
            e = model_exp(mode, pat, first + i);
            a.addr = first + i; a.we = (p == 0); a.dat = e;
            m_q.push_back(a);
            if (p == 1) begin
              rd = e & ~stuck;
              if (rd != e) begin
                if (m_err == 0) begin m_fail_addr = first + i; m_fail_exp = e; m_fail_act = rd; end
                m_err++;
              end
            end
          end
        end
      end
      m_done = m_q.size() * (lat + 1) + 1;
    end
  endtask

  // Mock RAM: done arrives m_lat cycles after each strobe.
  logic [7:0] mem [0:(1<<17)-1];
  int         lat_cnt;
  logic [AW-1:0] req_addr;
  always @(posedge clock_i) begin
    if (!mock_en) begin
      bus_done_i <= 1'b0; bus_data_i <= '0; lat_cnt <= 0; req_addr <= '0;
    end else begin
      bus_done_i <= 1'b0;
      if (bus_strobe_o) begin
        req_addr <= bus_addr_o;
        if (bus_we_o) mem[bus_addr_o] <= bus_data_o;
        if (m_lat == 1) begin
          bus_done_i <= 1'b1;
          bus_data_i <= mem[bus_addr_o] & ~m_stuck;
        end else lat_cnt <= m_lat - 1;
      end else if (lat_cnt > 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1) begin
          bus_done_i <= 1'b1;
          bus_data_i <= mem[req_addr] & ~m_stuck;
        end
      end
    end
  end

  // Per-cycle compare against the model while a test is tracked.
  initial begin
    acc_t a;
    int cyc;
    bit prev_strobe;
    gcyc = 0; prev_strobe = 0;
    forever begin
      @(negedge clock_i);
      if (track) begin
        cyc = gcyc - t0;
        if (bus_strobe_o) begin
          chk("strobe_b2b", 32'(prev_strobe), 32'(0));
          if (m_q.size() == 0) chk("extra_strobe", 32'(cyc), 32'(-1));
          else begin
            a = m_q.pop_front();
            chk("strobe_cyc", 32'(cyc), 32'(1 + n_strobe * (m_lat + 1)));
            chk("bus_addr", 32'(bus_addr_o), 32'(a.addr));
            chk("bus_we", 32'(bus_we_o), 32'(a.we));
            if (a.we) chk("bus_wdata", 32'(bus_data_o), 32'(a.dat));
          end
          n_strobe++;
        end
        chk("busy", 32'(busy_o), 32'(cyc >= 1 && cyc < m_done));
        chk("done", 32'(done_o), 32'(cyc == m_done));
        if (done_o && done_cyc < 0) done_cyc = cyc;
      end
      prev_strobe = bus_strobe_o;
      gcyc++;
    end
  end

  task automatic start_test(input int mode, input logic [7:0] pat, input int first, input int last);
    @(posedge clock_i); #1;
    mode_i = 2'(mode); pattern_i = pat; first_addr_i = AW'(first); last_addr_i = AW'(last);
    start_i = 1'b1; t0 = gcyc; track = 1'b1;
    @(posedge clock_i); #1;
    start_i = 1'b0;
  endtask

  task automatic finish_test(input string nm);
    int budget;
    budget = m_done + 20;
    for (int i = 0; i < budget && done_cyc < 0; i++) @(posedge clock_i);
    if (done_cyc < 0) chk({nm, "_timeout"}, 32'(0), 32'(1));
    repeat (2) @(posedge clock_i);
    #1;
    track = 1'b0;
    chk({nm, "_pass"}, 32'(pass_o), 32'(m_err == 0 && !m_abort && !m_range));
    chk({nm, "_err_count"}, 32'(error_count_o), 32'((m_err > 65535) ? 65535 : m_err));
    chk({nm, "_fail_addr"}, 32'(fail_addr_o), 32'(m_fail_addr));
    chk({nm, "_fail_exp"}, 32'(fail_expected_o), 32'(m_fail_exp));
    chk({nm, "_fail_act"}, 32'(fail_actual_o), 32'(m_fail_act));
    chk({nm, "_aborted"}, 32'(aborted_o), 32'(m_abort));
    chk({nm, "_range_err"}, 32'(range_error_o), 32'(m_range));
    chk({nm, "_all_strobes"}, 32'(m_q.size()), 32'(0));
  endtask

  task automatic check_results_zero(input string nm);
    chk({nm, "_busy"}, 32'(busy_o), 32'(0));
    chk({nm, "_strobe"}, 32'(bus_strobe_o), 32'(0));
    chk({nm, "_done"}, 32'(done_o), 32'(0));
    chk({nm, "_pass"}, 32'(pass_o), 32'(0));
    chk({nm, "_aborted"}, 32'(aborted_o), 32'(0));
    chk({nm, "_range_err"}, 32'(range_error_o), 32'(0));
    chk({nm, "_err_count"}, 32'(error_count_o), 32'(0));
    chk({nm, "_fail_addr"}, 32'(fail_addr_o), 32'(0));
    chk({nm, "_fail_exp"}, 32'(fail_expected_o), 32'(0));
    chk({nm, "_fail_act"}, 32'(fail_actual_o), 32'(0));
  endtask

  initial begin
    checks = 0; errors = 0; track = 0; mock_en = 0; t0 = 0;
    done_cyc = -1; n_strobe = 0; m_lat = 2; m_stuck = 8'h00; m_done = 0;
    reset_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; mode_i = 2'd0;
    pattern_i = '0; first_addr_i = '0; last_addr_i = '0;
    repeat (3) @(posedge clock_i);
    #1;
    check_results_zero("reset");
    chk("reset_addr", 32'(bus_addr_o), 32'(0));
    chk("reset_we", 32'(bus_we_o), 32'(0));
    reset_i = 1'b0; mock_en = 1'b1;
    repeat (2) @(posedge clock_i);

    // Full 256-word range, constant pattern.
    setup_model(0, 8'hA5, 0, 255, 2, 8'h00, -1);
    start_test(0, 8'hA5, 0, 255);
    finish_test("t1");
    chk("t1_done_cycle", 32'(done_cyc), 32'(1537));
    chk("t1_strobes", 32'(n_strobe), 32'(512));

    // Top of the address space; last_addr all-ones must not wrap.
    setup_model(1, 8'h00, 'h1FFF0, 'h1FFFF, 1, 8'h00, -1);
    start_test(1, 8'h00, 'h1FFF0, 'h1FFFF);
    finish_test("t2");
    chk("t2_done_cycle", 32'(done_cyc), 32'(65));
    chk("t2_last_addr", 32'(bus_addr_o), 32'('h1FFFF));

    // Bit 3 stuck at 0, walking one.
    setup_model(2, 8'h00, 0, 15, 2, 8'h08, -1);
    start_test(2, 8'h00, 0, 15);
    finish_test("t3");
    chk("t3_err_lit", 32'(error_count_o), 32'(2));
    chk("t3_fail_addr_lit", 32'(fail_addr_o), 32'(3));
    chk("t3_fail_exp_lit", 32'(fail_expected_o), 32'(8'h08));
    chk("t3_fail_act_lit", 32'(fail_actual_o), 32'(8'h00));
    chk("t3_pass_lit", 32'(pass_o), 32'(0));

    // Inverted range.
    setup_model(0, 8'h11, 'h10, 'h0F, 2, 8'h00, -1);
    start_test(0, 8'h11, 'h10, 'h0F);
    finish_test("t4");
    chk("t4_done_cycle", 32'(done_cyc), 32'(2));
    chk("t4_range_lit", 32'(range_error_o), 32'(1));

    // Abort in the third write's wait; a start while busy must be ignored.
    setup_model(0, 8'h3C, 'h20, 'h3F, 2, 8'h00, 3);
    start_test(0, 8'h3C, 'h20, 'h3F);
    repeat (3) @(posedge clock_i);
    #1;
    mode_i = 2'd1; first_addr_i = AW'('h40); last_addr_i = AW'('h41); start_i = 1'b1;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clock_i);
    #1;
    abort_i = 1'b1;
    @(posedge clock_i); #1;
    abort_i = 1'b0;
    finish_test("t5");
    chk("t5_done_cycle", 32'(done_cyc), 32'(10));
    chk("t5_strobes", 32'(n_strobe), 32'(3));
    chk("t5_aborted_lit", 32'(aborted_o), 32'(1));

    // Reset during the read pass, after a mismatch has been counted and with a done in flight.
    setup_model(1, 8'h00, 0, 15, 2, 8'h01, -1);
    start_test(1, 8'h00, 0, 15);
    repeat (58) @(posedge clock_i);
    #1;
    chk("t6_err_before_reset", 32'(error_count_o), 32'(1));
    reset_i = 1'b1;
    @(posedge clock_i); #1;
    reset_i = 1'b0; track = 1'b0;
    m_q.delete();
    check_results_zero("t6_after_reset");
    for (int i = 0; i < 5; i++) begin
      @(posedge clock_i); #1;
      chk("t6_idle_strobe", 32'(bus_strobe_o), 32'(0));
      chk("t6_idle_busy", 32'(busy_o), 32'(0));
    end

    // A full test after reset must pass.
    setup_model(3, 8'h5A, 'h100, 'h107, 3, 8'h00, -1);
    start_test(3, 8'h5A, 'h100, 'h107);
    finish_test("t7");
    chk("t7_done_cycle", 32'(done_cyc), 32'(65));
    chk("t7_pass_lit", 32'(pass_o), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
